nco_cfg_ctrl: RTL and testbench



---
 rtl/nco_cfg_ctrl.sv | 136 +++++++++++++
 tb/tb_nco_cfg_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nco_cfg_ctrl.sv
// Serialises one parallel NCO config request into four nco_param words, then issues config_sync (immediate or frame-aligned).
// Latency: words at T+1..T+4 after accept, config_sync at T+5 (immediate) or one cycle after a sampled frame_strobe.
// Backpressure: cfg_ready is high only in IDLE. Optional NCO_READBACK_CHECK_EN adds nco_freq_rb/cfg_err frequency readback compare.
module nco_cfg_ctrl #(
    parameter int BUSBITWIDTH  = 16,
    parameter int SYNC_TIMEOUT = 1023,
    parameter int TO_W         = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [2*BUSBITWIDTH-1:0] cfg_freq,
    input  logic [BUSBITWIDTH-1:0]   cfg_phase,
    input  logic [BUSBITWIDTH-2:0]   cfg_test,
    input  logic                     cfg_inv,
    input  logic                     cfg_sync_mode,
    input  logic                     frame_strobe,
    output logic                     nco_indicator,
    output logic [BUSBITWIDTH-1:0]   nco_param,
    output logic                     config_sync,
    output logic                     busy,
    output logic                     done,
`ifdef NCO_READBACK_CHECK_EN
    input  logic [2*BUSBITWIDTH-1:0] nco_freq_rb,
    output logic                     cfg_err,
`endif
    output logic                     sync_timeout
);

    typedef enum logic [2:0] {IDLE, LOAD, WAIT_SYNC, SYNC, DONE} state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'((SYNC_TIMEOUT == 0) ? 0 : SYNC_TIMEOUT - 1);

    state_t                   state;
    logic [1:0]               word_cnt;
    logic [TO_W-1:0]          to_cnt;
    logic [2*BUSBITWIDTH-1:0] cap_freq;
    logic [BUSBITWIDTH-1:0]   cap_phase;
    logic                     cap_mode;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            word_cnt      <= '0;
            to_cnt        <= '0;
            cap_freq      <= '0;
            cap_phase     <= '0;
            cap_mode      <= 1'b0;
            cfg_ready     <= 1'b0;
            nco_indicator <= 1'b0;
            nco_param     <= '0;
            config_sync   <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            sync_timeout  <= 1'b0;
`ifdef NCO_READBACK_CHECK_EN
            cfg_err       <= 1'b0;
`endif
        end else begin
            config_sync  <= 1'b0;
            done         <= 1'b0;
            sync_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    cfg_ready <= 1'b1;
                    if (cfg_valid && cfg_ready) begin
                        // W0 goes out straight from the inputs; only later words need the capture.
                        cap_freq      <= cfg_freq;
                        cap_phase     <= cfg_phase;
                        cap_mode      <= cfg_sync_mode;
                        word_cnt      <= '0;
                        nco_indicator <= 1'b1;
                        nco_param     <= {cfg_test, cfg_inv};
                        cfg_ready     <= 1'b0;
                        busy          <= 1'b1;
                        state         <= LOAD;
`ifdef NCO_READBACK_CHECK_EN
                        cfg_err       <= 1'b0;
`endif
                    end
                end
                LOAD: begin
                    word_cnt <= word_cnt + 2'd1;
                    case (word_cnt)
                        2'd0:    nco_param <= cap_freq[BUSBITWIDTH-1:0];
                        2'd1:    nco_param <= cap_freq[2*BUSBITWIDTH-1:BUSBITWIDTH];
                        2'd2:    nco_param <= cap_phase;
                        default: begin
                            nco_indicator <= 1'b0;
                            nco_param     <= '0;
                            to_cnt        <= '0;
                            if (cap_mode) begin
                                state <= WAIT_SYNC;
                            end else begin
                                config_sync <= 1'b1;
                                state       <= SYNC;
                            end
                        end
                    endcase
                end
                WAIT_SYNC: begin
                    // A strobe on the final allowed cycle still wins over the timeout.
                    if (frame_strobe) begin
                        config_sync <= 1'b1;
                        state       <= SYNC;
                    end else if ((SYNC_TIMEOUT != 0) && (to_cnt == TO_LAST)) begin
                        sync_timeout <= 1'b1;
                        busy         <= 1'b0;
                        cfg_ready    <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                SYNC: begin
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    busy      <= 1'b0;
                    cfg_ready <= 1'b1;
                    state     <= IDLE;
`ifdef NCO_READBACK_CHECK_EN
                    // The NCO has taken the new frequency by now, so readback must match.
                    if (nco_freq_rb != cap_freq) begin
                        cfg_err <= 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nco_cfg_ctrl.sv
// Randomised bench for nco_cfg_ctrl: per-request event schedule model plus a tiny NCO shift/latch model.
module tb_nco_cfg_ctrl;

    localparam int N_TO = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_freq;
    logic [15:0] cfg_phase;
    logic [14:0] cfg_test;
    logic        cfg_inv;
    logic        cfg_sync_mode;
    logic        frame_strobe;
    logic        nco_indicator;
    logic [15:0] nco_param;
    logic        config_sync;
    logic        busy;
    logic        done;
    logic        sync_timeout;
    logic        err_obs;

    // Downstream NCO model: 4-stage shift, live frequency latched on config_sync.
    logic [15:0] sr0 = '0, sr1 = '0, sr2 = '0, sr3 = '0;
    logic [31:0] nco_live = '0;
    bit          force_rb = 1'b0;
    bit          b2b_mode0 = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (nco_indicator) begin
            sr3 <= sr2;
            sr2 <= sr1;
            sr1 <= sr0;
            sr0 <= nco_param;
        end
        if (config_sync) nco_live <= {sr1, sr2};
    end

`ifdef NCO_READBACK_CHECK_EN
    logic [31:0] nco_freq_rb;
    logic        cfg_err;
    assign nco_freq_rb = force_rb ? 32'h0 : nco_live;
    assign err_obs     = cfg_err;
`else
    assign err_obs     = 1'b0;
`endif

    nco_cfg_ctrl #(.BUSBITWIDTH(16), .SYNC_TIMEOUT(N_TO), .TO_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_freq     (cfg_freq),
        .cfg_phase    (cfg_phase),
        .cfg_test     (cfg_test),
        .cfg_inv      (cfg_inv),
        .cfg_sync_mode(cfg_sync_mode),
        .frame_strobe (frame_strobe),
        .nco_indicator(nco_indicator),
        .nco_param    (nco_param),
        .config_sync  (config_sync),
        .busy         (busy),
        .done         (done),
`ifdef NCO_READBACK_CHECK_EN
        .nco_freq_rb  (nco_freq_rb),
        .cfg_err      (cfg_err),
`endif
        .sync_timeout (sync_timeout)
    );

    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] exp_live = '0;
    bit          err_state = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    endtask

    function automatic logic [31:0] obs_vec();
        return {9'b0, cfg_ready, busy, nco_indicator, nco_param, config_sync, done, sync_timeout, err_obs};
    endfunction

    function automatic logic [31:0] vec(input bit rdy, input bit bsy, input bit ind, input logic [15:0] prm,
                                        input bit syn, input bit dn, input bit to, input bit err);
        return {9'b0, rdy, bsy, ind, prm, syn, dn, to, err};
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_val("idle", obs_vec(), vec(1, 0, 0, 16'h0, 0, 0, 0, err_state));
            frame_strobe = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic set_req(input logic [31:0] f, input logic [15:0] p, input logic [14:0] t,
                           input bit inv, input bit mode);
        cfg_freq = f; cfg_phase = p; cfg_test = t; cfg_inv = inv; cfg_sync_mode = mode;
        cfg_valid = 1'b1;
    endtask

    task automatic rand_data(input bit valid);
        cfg_freq      = $urandom;
        cfg_phase     = 16'($urandom);
        cfg_test      = 15'($urandom);
        cfg_inv       = 1'($urandom);
        cfg_sync_mode = b2b_mode0 ? 1'b0 : 1'($urandom);
        cfg_valid     = valid;
    endtask

    // Called between a negedge and the accept posedge with a request presented and the DUT idle.
    // sa/sb: edge offsets after accept at which frame_strobe is sampled high (0 = none).
    task automatic do_txn(input int sa, input int sb, input bit keep, input int rst_at);
        logic [15:0] w[4];
        logic [31:0] f;
        bit          m;
        int          first, sync_l, done_l, to_l, rdy_l;
        logic [31:0] exp;
        f    = cfg_freq;
        m    = cfg_sync_mode;
        w[0] = {cfg_test, cfg_inv};
        w[1] = cfg_freq[15:0];
        w[2] = cfg_freq[31:16];
        w[3] = cfg_phase;
        sync_l = 0; done_l = 0; to_l = 0;
        if (!m) begin
            sync_l = 5; done_l = 6; rdy_l = 7;
        end else begin
            first = 0;
            if (sa >= 5 && sa <= 4 + N_TO) first = sa;
            if (sb >= 5 && sb <= 4 + N_TO && (first == 0 || sb < first)) first = sb;
            if (first != 0) begin
                sync_l = first + 1; done_l = first + 2; rdy_l = first + 3;
            end else begin
                to_l = N_TO + 5; rdy_l = N_TO + 5;
            end
        end
        @(posedge clk);
        #1 rand_data(keep);
        for (int t = 1; t <= rdy_l; t++) begin
            @(negedge clk);
            if (t == 1) err_state = 1'b0;
            if (t == rdy_l && done_l != 0) err_state = force_rb && (f != 32'h0);
            exp = vec(t >= rdy_l, t < rdy_l, t <= 4, (t <= 4) ? w[t-1] : 16'h0,
                      t == sync_l, t == done_l, t == to_l, err_state);
            check_val("trace", obs_vec(), exp);
            if (t == rdy_l) begin
                if (sync_l != 0) exp_live = f;
                check_val("nco_freq", {32'h0, nco_live}, {32'h0, exp_live});
            end
            if (t == rst_at) begin
                rst = 1'b0; cfg_valid = 1'b0; frame_strobe = 1'b0;
                #1 check_val("rst_mid", obs_vec(), 32'h0);
                err_state = 1'b0;
                @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                check_val("rst_recover", obs_vec(), vec(1, 0, 0, 16'h0, 0, 0, 0, 0));
                check_val("nco_keep", {32'h0, nco_live}, {32'h0, exp_live});
                return;
            end
            frame_strobe = (t == sa || t == sb);
        end
        frame_strobe = 1'b0;
    endtask

    initial begin
        rst = 1'b0; cfg_valid = 1'b0; frame_strobe = 1'b0;
        cfg_freq = '0; cfg_phase = '0; cfg_test = '0; cfg_inv = 1'b0; cfg_sync_mode = 1'b0;
        repeat (2) @(negedge clk);
        check_val("reset", obs_vec(), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        check_val("ready_after_rst", obs_vec(), vec(1, 0, 0, 16'h0, 0, 0, 0, 0));

        // Immediate-mode directed request; W0 = 16'h0007.
        set_req(32'h1234_5678, 16'h00AA, 15'h0003, 1'b1, 1'b0);
        do_txn(0, 0, 0, 0);
        check_val("freq_directed", {32'h0, nco_live}, 64'h1234_5678);
        idle(2);

        // Frame-aligned: strobe in LOAD ignored, strobe at offset 20 used.
        set_req($urandom, 16'h1111, 15'h0042, 1'b0, 1'b1);
        do_txn(2, 20, 0, 0);
        idle(2);

        // Frame-aligned with no strobe: timeout.
        set_req(32'hCAFE_F00D, 16'h2222, 15'h0001, 1'b1, 1'b1);
        do_txn(0, 0, 0, 0);
        idle(1);

        // Valid held high: accepts every 7 cycles.
        b2b_mode0 = 1'b1;
        set_req($urandom, 16'h3333, 15'h0005, 1'b0, 1'b0);
        do_txn(0, 0, 1, 0);
        do_txn(0, 0, 1, 0);
        do_txn(0, 0, 0, 0);
        b2b_mode0 = 1'b0;
        idle(1);

        // Reset in the middle of a load, then a clean request.
        set_req(32'hDEAD_BEEF, 16'h4444, 15'h0007, 1'b1, 1'b0);
        do_txn(0, 0, 0, 3);
        idle(1);
        set_req(32'h0BAD_CAFE, 16'h5555, 15'h0009, 1'b0, 1'b0);
        do_txn(0, 0, 0, 0);

        for (int i = 0; i < 25; i++) begin
            int sa, sb, ra;
            sa = $urandom_range(0, 30);
            sb = $urandom_range(0, 30);
            ra = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 4) : 0;
            if (!cfg_valid) begin
                idle($urandom_range(0, 3));
                rand_data(1'b1);
            end
            do_txn(sa, sb, 1'($urandom_range(0, 1)), ra);
        end
        if (cfg_valid) do_txn(0, 0, 0, 0);

`ifdef NCO_READBACK_CHECK_EN
        idle(1);
        force_rb = 1'b1;
        set_req(32'h1, 16'h0, 15'h0, 1'b0, 1'b0);
        do_txn(0, 0, 0, 0);
        idle(2);
        force_rb = 1'b0;
        set_req(32'h1, 16'h0, 15'h0, 1'b0, 1'b0);
        do_txn(0, 0, 0, 0);
`endif
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
